// File: rtl/gen_demux_packer_pkg.sv
// Shared types and sizing helpers for the word demux packer (package gen_pkg).
package gen_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int unsigned slots(input int unsigned sel);
        return 32'd1 << sel;
    endfunction

    function automatic int unsigned frame_width(input int unsigned bus_width, input int unsigned sel);
        return bus_width * slots(sel);
    endfunction

endpackage

// File: rtl/gen_demux_packer_if.sv
// Word-in / frame-out handshake bundle for gen_demux_packer.
// Carries out_parity only when GEN_DEMUX_PACKER_PARITY_EN is defined.
interface gen_demux_packer_if
    import gen_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned SEL       = 5
);
    localparam int unsigned FW = frame_width(BUS_WIDTH, SEL);

    logic                 in_valid;
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_ready;
    logic                 flush;
    logic [FW-1:0]        data_out;
    logic [SEL:0]         out_count;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL-1:0]       wr_ptr;
`ifdef GEN_DEMUX_PACKER_PARITY_EN
    logic                 out_parity;
`endif

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, data_out, out_count, out_valid, wr_ptr
`ifdef GEN_DEMUX_PACKER_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, data_out, out_count, out_valid, wr_ptr
`ifdef GEN_DEMUX_PACKER_PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/gen_demux_packer_slot_decoder.sv
// Maps the write pointer and a write enable to a one-hot slot-enable vector.
module gen_slot_decoder
    import gen_pkg::*;
#(
    parameter int unsigned SEL = 5
) (
    input  logic [SEL-1:0]         wr_ptr,
    input  logic                   we,
    output logic [slots(SEL)-1:0]  slot_en
);
    localparam int unsigned SLOTS = slots(SEL);

    always_comb begin
        slot_en = '0;
        for (int k = 0; k < SLOTS; k++) begin
            slot_en[k] = we && (wr_ptr == SEL'(k));
        end
    end

endmodule

// File: rtl/gen_demux_packer.sv
// Packs BUS_WIDTH-bit words into a 2**SEL-slot frame and hands it off with valid/ready.
// Optional frame parity output enabled by GEN_DEMUX_PACKER_PARITY_EN.
module gen_demux_packer
    import gen_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned SEL       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    gen_demux_packer_if.slave  bus
);
    localparam int unsigned SLOTS = slots(SEL);
    localparam int unsigned FW    = frame_width(BUS_WIDTH, SEL);
    localparam int unsigned CW    = SEL + 1;

    state_e               state_q;
    state_e               state_d;
    logic [FW-1:0]        frame_q;
    logic [SEL-1:0]       wr_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 valid_q;

    logic                 in_ready_c;
    logic                 accept_c;
    logic                 last_c;
    logic                 close_c;
    logic                 release_c;
    logic [SLOTS-1:0]     slot_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close_c)   state_d = HOLD;
            HOLD:    if (release_c) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Handshake decode; a flush at an empty frame never closes it
    always_comb begin
        in_ready_c = 1'b0;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        close_c    = 1'b0;
        release_c  = 1'b0;
        if (state_q == FILL) begin
            in_ready_c = 1'b1;
            accept_c   = bus.in_valid;
            last_c     = accept_c && (wr_ptr_q == SEL'(SLOTS - 1));
            close_c    = last_c || (bus.flush && (accept_c || (wr_ptr_q != '0)));
        end else begin
            release_c  = valid_q && bus.out_ready;
        end
    end

    gen_slot_decoder #(.SEL(SEL)) u_slot_decoder (
        .wr_ptr  (wr_ptr_q),
        .we      (accept_c),
        .slot_en (slot_en)
    );

    // Frame, pointer and count registers; the frame is wiped as it is handed off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else if (release_c) begin
            frame_q  <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                if (slot_en[k]) begin
                    frame_q[k*BUS_WIDTH +: BUS_WIDTH] <= bus.in_data;
                end
            end
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + SEL'(1);
            end
            if (close_c) begin
                wr_ptr_q <= '0;
                valid_q  <= 1'b1;
                count_q  <= accept_c ? (CW'(wr_ptr_q) + CW'(1)) : CW'(wr_ptr_q);
            end
        end
    end

`ifdef GEN_DEMUX_PACKER_PARITY_EN
    logic parity_q;

    // Running XOR of accepted words; stable through HOLD since nothing is accepted there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (release_c) begin
            parity_q <= 1'b0;
        end else if (accept_c) begin
            parity_q <= parity_q ^ (^bus.in_data);
        end
    end

    assign bus.out_parity = parity_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.data_out  = frame_q;
    assign bus.out_count = count_q;
    assign bus.out_valid = valid_q;
    assign bus.wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_gen_demux_packer.sv
// Randomized bench for gen_demux_packer (BUS_WIDTH=4, SEL=2) against a queue-based frame model.
module tb_gen_demux_packer;
    localparam int unsigned BW = 4;
    localparam int unsigned SL = 2;
    localparam int unsigned NS = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gen_demux_packer_if #(.BUS_WIDTH(BW), .SEL(SL)) bus ();

    gen_demux_packer #(.BUS_WIDTH(BW), .SEL(SL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words of the open frame, plus the closed frame while held
    logic [3:0]  mw[$];
    bit          mhold;
    logic [15:0] mframe;
    int          mcount;
    bit          mpar;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_words();
        logic [15:0] v;
        v = '0;
        foreach (mw[i]) v = v | (16'(mw[i]) << (4 * i));
        return v;
    endfunction

    function automatic bit xor_words();
        bit p;
        p = 1'b0;
        foreach (mw[i]) p = p ^ (^mw[i]);
        return p;
    endfunction

    task automatic model_reset();
        mw.delete();
        mhold  = 1'b0;
        mframe = '0;
        mcount = 0;
        mpar   = 1'b0;
    endtask

    task automatic model_step(input logic iv, input logic [3:0] id, input logic fl, input logic ordy);
        if (!mhold) begin
            if (iv) mw.push_back(id);
            if (mw.size() == NS || (fl && mw.size() > 0)) begin
                mframe = pack_words();
                mcount = mw.size();
                mpar   = xor_words();
                mhold  = 1'b1;
                mw.delete();
            end
        end else if (ordy) begin
            mhold = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(mhold));
        chk("in_ready", 32'(bus.in_ready), 32'(!mhold));
        if (mhold) begin
            chk("frame", 32'(bus.data_out), 32'(mframe));
            chk("count", 32'(bus.out_count), 32'(mcount));
            chk("wr_ptr_hold", 32'(bus.wr_ptr), 32'd0);
`ifdef GEN_DEMUX_PACKER_PARITY_EN
            chk("parity", 32'(bus.out_parity), 32'(mpar));
`endif
        end else begin
            chk("partial", 32'(bus.data_out), 32'(pack_words()));
            chk("wr_ptr", 32'(bus.wr_ptr), 32'(mw.size()));
        end
    endtask

    // Drive at negedge, let the posedge act, check at the following negedge
    task automatic cyc(input logic iv, input logic [3:0] id, input logic fl, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(posedge clk);
        model_step(iv, id, fl, ordy);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset values, then release away from a clock edge
        #1;
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_ptr", 32'(bus.wr_ptr), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        #22 rst_n = 1'b1;
        #1;
        chk("rel_data", 32'(bus.data_out), 32'd0);
        chk("rel_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_outputs();

        // Full frame then handoff
        cyc(1, 4'h1, 0, 0);
        cyc(1, 4'h2, 0, 0);
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h4, 0, 0);
        chk("t2_frame", 32'(bus.data_out), 32'h4321);
        chk("t2_count", 32'(bus.out_count), 32'd4);
        cyc(0, 4'h0, 0, 1);
        chk("t2_cleared", 32'(bus.data_out), 32'd0);

        // Backpressure with words offered during HOLD
        for (int i = 0; i < 4; i++) cyc(1, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 4'hF, 0, 0);
            chk("t3_held", 32'(bus.data_out), 32'hFFFF);
            chk("t3_noready", 32'(bus.in_ready), 32'd0);
        end
        cyc(1, 4'hF, 0, 1);
        cyc(1, 4'h5, 0, 0);
        chk("t3_slot0", 32'(bus.data_out), 32'h0005);
        chk("t3_ptr", 32'(bus.wr_ptr), 32'd1);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 1);

        // Partial flushes and an ignored empty flush
        cyc(1, 4'hA, 0, 0);
        cyc(1, 4'hB, 0, 0);
        cyc(0, 4'h0, 1, 0);
        chk("t4_count2", 32'(bus.out_count), 32'd2);
        chk("t4_frame2", 32'(bus.data_out), 32'h00BA);
        cyc(0, 4'h0, 1, 1);
        cyc(1, 4'hA, 0, 0);
        cyc(1, 4'hB, 0, 0);
        cyc(1, 4'hC, 1, 0);
        chk("t4_count3", 32'(bus.out_count), 32'd3);
        chk("t4_frame3", 32'(bus.data_out), 32'h0CBA);
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 1, 0);
        chk("t4_empty_flush", 32'(bus.out_valid), 32'd0);
        cyc(0, 4'h0, 0, 0);

        // Reset mid-frame discards the partial words
        cyc(1, 4'h7, 0, 0);
        cyc(1, 4'h9, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_ptr", 32'(bus.wr_ptr), 32'd0);
        chk("t5_data", 32'(bus.data_out), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 1);

`ifdef GEN_DEMUX_PACKER_PARITY_EN
        cyc(1, 4'h1, 0, 0);
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 0, 0);
        chk("t6_par1", 32'(bus.out_parity), 32'd1);
        cyc(0, 4'h0, 0, 1);
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h0, 0, 0);
        cyc(1, 4'h0, 0, 0);
        chk("t6_par0", 32'(bus.out_parity), 32'd0);
        cyc(0, 4'h0, 0, 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
